// File: rtl/packet_scheduler.sv
// Buffers audio sample pairs and picks one data-island packet per slot (sample > ACR > InfoFrame > null).
// Selection registers 1 cycle after packet_slot; audio_ready drops while the sample FIFO is full.

module sync_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  output logic         push_rdy,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         head_vld,
  output logic [W-1:0] head_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign push_rdy = (count != (AW+1)'(DEPTH));
  assign head_vld = (count != '0);
  // Head reads as zero when empty so downstream never sees stale storage.
  assign head_dat = head_vld ? mem[rd_ptr] : '0;
  assign do_push  = push_vld && push_rdy;
  assign do_pop   = pop && head_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module packet_scheduler #(
  parameter int ACR_INTERVAL     = 25200,
  parameter int AUDIO_FIFO_DEPTH = 4
) (
  input  logic             clk_pixel,
  input  logic             reset_n,
  input  logic             packet_slot,
  input  logic             video_field_end,
  input  logic             audio_valid,
  output logic             audio_ready,
  input  logic [1:0][23:0] audio_sample_word_in,
  output logic [7:0]       frame_counter,
  output logic [1:0][23:0] audio_sample_word,
  input  logic [23:0]      asp_header,
  input  logic [3:0][55:0] asp_sub,
  input  logic [23:0]      acr_header,
  input  logic [3:0][55:0] acr_sub,
  input  logic [23:0]      aif_header,
  input  logic [3:0][55:0] aif_sub,
  output logic [23:0]      header,
  output logic [3:0][55:0] sub,
  output logic [7:0]       packet_type
);
  localparam int             TW         = (ACR_INTERVAL > 1) ? $clog2(ACR_INTERVAL) : 1;
  localparam logic [TW-1:0]  ACR_LAST   = TW'(ACR_INTERVAL - 1);
  localparam logic [7:0]     FRAME_LAST = 8'd191;
  localparam logic [7:0]     PT_NULL    = 8'h00;
  localparam logic [7:0]     PT_ACR     = 8'h01;
  localparam logic [7:0]     PT_ASP     = 8'h02;
  localparam logic [7:0]     PT_AIF     = 8'h84;

  typedef enum logic [1:0] {SEL_NULL, SEL_ASP, SEL_ACR, SEL_AIF} sel_t;

  logic [TW-1:0] acr_timer;
  logic          acr_tc;
  logic          acr_pending;
  logic          aif_pending;
  logic          fifo_head_vld;
  logic [47:0]   fifo_head_dat;
  logic          grant_asp;
  logic          grant_acr;
  logic          grant_aif;
  sel_t          sel;

  sync_fifo #(.W(48), .DEPTH(AUDIO_FIFO_DEPTH)) u_audio_fifo (
    .clk      (clk_pixel),
    .rst_n    (reset_n),
    .push_vld (audio_valid),
    .push_rdy (audio_ready),
    .push_dat (audio_sample_word_in),
    .pop      (grant_asp),
    .head_vld (fifo_head_vld),
    .head_dat (fifo_head_dat)
  );

  assign audio_sample_word = fifo_head_dat;
  assign acr_tc            = (acr_timer == ACR_LAST);

  always_comb begin
    sel = SEL_NULL;
    if (fifo_head_vld)    sel = SEL_ASP;
    else if (acr_pending) sel = SEL_ACR;
    else if (aif_pending) sel = SEL_AIF;
  end

  assign grant_asp = packet_slot && (sel == SEL_ASP);
  assign grant_acr = packet_slot && (sel == SEL_ACR);
  assign grant_aif = packet_slot && (sel == SEL_AIF);

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      acr_timer     <= '0;
      acr_pending   <= 1'b0;
      aif_pending   <= 1'b1;
      frame_counter <= '0;
      header        <= '0;
      sub           <= '0;
      packet_type   <= PT_NULL;
    end else begin
      acr_timer <= acr_tc ? '0 : acr_timer + 1'b1;
      // A fresh request in the grant cycle wins over the clear.
      acr_pending <= acr_tc | (acr_pending & ~grant_acr);
      aif_pending <= video_field_end | (aif_pending & ~grant_aif);
      if (grant_asp) begin
        frame_counter <= (frame_counter == FRAME_LAST) ? 8'd0 : frame_counter + 8'd1;
      end
      if (packet_slot) begin
        case (sel)
          SEL_ASP: begin header <= asp_header; sub <= asp_sub; packet_type <= PT_ASP; end
          SEL_ACR: begin header <= acr_header; sub <= acr_sub; packet_type <= PT_ACR; end
          SEL_AIF: begin header <= aif_header; sub <= aif_sub; packet_type <= PT_AIF; end
          default: begin header <= '0;         sub <= '0;      packet_type <= PT_NULL; end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_packet_scheduler.sv
// Scoreboard bench for packet_scheduler: a transaction model predicts each slot's packet.
module tb_packet_scheduler;
  localparam int ACR_N = 100;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0]       ptype;
    logic [23:0]      hdr;
    logic [3:0][55:0] sub;
  } pkt_t;

  localparam logic [23:0] ACR_HDR  = 24'h000001;
  localparam logic [55:0] ACR_SP   = 56'h00180000627000;
  localparam logic [23:0] AIF_HDR  = 24'h0A0184;
  localparam logic [55:0] AIF_SP   = 56'h00000000011A70;
  localparam pkt_t        ACR_PKT  = {8'h01, ACR_HDR, {4{ACR_SP}}};
  localparam pkt_t        AIF_PKT  = {8'h84, AIF_HDR, {4{AIF_SP}}};
  localparam pkt_t        NULL_PKT = '0;

  logic             clk_pixel = 1'b0;
  logic             reset_n = 1'b1;
  logic             packet_slot = 1'b0;
  logic             video_field_end = 1'b0;
  logic             audio_valid = 1'b0;
  logic             audio_ready;
  logic [1:0][23:0] audio_sample_word_in = '0;
  logic [7:0]       frame_counter;
  logic [1:0][23:0] audio_sample_word;
  logic [23:0]      asp_header;
  logic [3:0][55:0] asp_sub;
  logic [23:0]      acr_header;
  logic [3:0][55:0] acr_sub;
  logic [23:0]      aif_header;
  logic [3:0][55:0] aif_sub;
  logic [23:0]      header;
  logic [3:0][55:0] sub;
  logic [7:0]       packet_type;

  // Stand-in sample-packet generator: B flag (bit 20) only at frame 0.
  assign asp_header = {3'b000, frame_counter == 8'd0, 4'h0, frame_counter, 8'h02};
  assign asp_sub    = {4{audio_sample_word[1], audio_sample_word[0], 8'h00}};
  assign acr_header = ACR_HDR;
  assign acr_sub    = {4{ACR_SP}};
  assign aif_header = AIF_HDR;
  assign aif_sub    = {4{AIF_SP}};

  packet_scheduler #(.ACR_INTERVAL(ACR_N), .AUDIO_FIFO_DEPTH(DEPTH)) dut (
    .clk_pixel            (clk_pixel),
    .reset_n              (reset_n),
    .packet_slot          (packet_slot),
    .video_field_end      (video_field_end),
    .audio_valid          (audio_valid),
    .audio_ready          (audio_ready),
    .audio_sample_word_in (audio_sample_word_in),
    .frame_counter        (frame_counter),
    .audio_sample_word    (audio_sample_word),
    .asp_header           (asp_header),
    .asp_sub              (asp_sub),
    .acr_header           (acr_header),
    .acr_sub              (acr_sub),
    .aif_header           (aif_header),
    .aif_sub              (aif_sub),
    .header               (header),
    .sub                  (sub),
    .packet_type          (packet_type)
  );

  always #5 clk_pixel = ~clk_pixel;

  int          total = 0;
  int          bad = 0;
  int          m_timer;
  bit          m_acr;
  bit          m_aif;
  logic [47:0] m_fifo[$];
  logic [7:0]  m_fc;
  pkt_t        exp_q[$];

  function automatic pkt_t asp_pkt(input logic [7:0] fc, input logic [47:0] w);
    pkt_t p;
    p.ptype = 8'h02;
    p.hdr   = {3'b000, fc == 8'd0, 4'h0, fc, 8'h02};
    for (int i = 0; i < 4; i++) p.sub[i] = {w[47:24], w[23:0], 8'h00};
    return p;
  endfunction

  function automatic logic [47:0] rnd_word();
    return {24'($urandom), 24'($urandom)};
  endfunction

  function automatic pkt_t dut_pkt();
    return {packet_type, header, sub};
  endfunction

  task automatic model_reset();
    m_timer = 0;
    m_acr   = 1'b0;
    m_aif   = 1'b1;
    m_fc    = 8'd0;
    m_fifo.delete();
    exp_q.delete();
  endtask

  // One clock: drive inputs, predict, advance one edge, sample 1 ns later.
  task automatic cycle(input logic slot, input logic vfe, input logic av, input logic [47:0] w);
    bit tc, push, clr_acr, clr_aif;
    packet_slot          = slot;
    video_field_end      = vfe;
    audio_valid          = av;
    audio_sample_word_in = w;
    tc      = (m_timer == ACR_N - 1);
    push    = av && (m_fifo.size() < DEPTH);
    clr_acr = 1'b0;
    clr_aif = 1'b0;
    if (slot) begin
      if (m_fifo.size() != 0) begin
        exp_q.push_back(asp_pkt(m_fc, m_fifo.pop_front()));
        m_fc = (m_fc == 8'd191) ? 8'd0 : m_fc + 8'd1;
      end else if (m_acr) begin
        exp_q.push_back(ACR_PKT);
        clr_acr = 1'b1;
      end else if (m_aif) begin
        exp_q.push_back(AIF_PKT);
        clr_aif = 1'b1;
      end else begin
        exp_q.push_back(NULL_PKT);
      end
    end
    if (push) m_fifo.push_back(w);
    m_acr   = tc || (m_acr && !clr_acr);
    m_aif   = vfe || (m_aif && !clr_aif);
    m_timer = tc ? 0 : m_timer + 1;
    @(posedge clk_pixel);
    #1;
    packet_slot     = 1'b0;
    video_field_end = 1'b0;
    audio_valid     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    audio_valid = 1'b1;
    repeat (3) @(posedge clk_pixel);
    #1;
    total++;
    if (audio_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", audio_ready); end
    total++;
    if (dut_pkt() !== NULL_PKT) begin bad++; $display("FAIL reset_pkt got=%h exp=0", dut_pkt()); end
    total++;
    if (frame_counter !== 8'd0) begin bad++; $display("FAIL reset_fc got=%0d exp=0", frame_counter); end
    total++;
    if (audio_sample_word !== 48'd0) begin bad++; $display("FAIL reset_head got=%h exp=0", audio_sample_word); end
    audio_valid = 1'b0;
    reset_n     = 1'b1;
    model_reset();
  endtask

  task automatic test_aif_first();
    pkt_t e;
    idle(10);
    cycle(1'b1, 1'b0, 1'b0, '0);
    e = exp_q.pop_front();
    total++;
    if (packet_type !== 8'h84 || header !== AIF_HDR) begin
      bad++; $display("FAIL aif_first type=%h hdr=%h exp type=84 hdr=%h", packet_type, header, AIF_HDR);
    end
    total++;
    if (dut_pkt() !== e) begin bad++; $display("FAIL aif_first_pkt got=%h exp=%h", dut_pkt(), e); end
    idle(31);
    cycle(1'b1, 1'b0, 1'b0, '0);
    e = exp_q.pop_front();
    total++;
    if (packet_type !== 8'h00 || header !== 24'd0 || sub !== '0) begin
      bad++; $display("FAIL null_after_aif got=%h exp=0", dut_pkt());
    end
    total++;
    if (dut_pkt() !== e) begin bad++; $display("FAIL null_pkt got=%h exp=%h", dut_pkt(), e); end
  endtask

  task automatic test_fill_drain();
    pkt_t e;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b1, rnd_word());
      total++;
      if (audio_ready !== (i < 3)) begin bad++; $display("FAIL fill_ready[%0d] got=%b exp=%b", i, audio_ready, i < 3); end
    end
    idle(31);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (frame_counter !== 8'(i)) begin bad++; $display("FAIL drain_fc[%0d] got=%0d exp=%0d", i, frame_counter, i); end
      cycle(1'b1, 1'b0, 1'b0, '0);
      e = exp_q.pop_front();
      total++;
      if (packet_type !== 8'h02 || dut_pkt() !== e) begin
        bad++; $display("FAIL drain_pkt[%0d] got=%h exp=%h", i, dut_pkt(), e);
      end
      if (i == 0) begin
        total++;
        if (audio_ready !== 1'b1) begin bad++; $display("FAIL ready_after_pop got=%b exp=1", audio_ready); end
      end
      idle(31);
    end
  endtask

  task automatic test_acr_period();
    pkt_t e;
    int   n, acr_cnt;
    bit   prev_acr;
    n = 0;
    while (m_timer != 10 && n < 2 * ACR_N) begin idle(1); n++; end
    cycle(1'b1, 1'b0, 1'b0, '0);
    e = exp_q.pop_front();
    total++;
    if (dut_pkt() !== e) begin bad++; $display("FAIL acr_drain got=%h exp=%h", dut_pkt(), e); end
    acr_cnt  = 0;
    prev_acr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      idle(39);
      cycle(1'b1, 1'b0, 1'b0, '0);
      e = exp_q.pop_front();
      total++;
      if (dut_pkt() !== e) begin bad++; $display("FAIL acr_slot[%0d] got=%h exp=%h", k, dut_pkt(), e); end
      total++;
      if (prev_acr && packet_type === 8'h01) begin bad++; $display("FAIL acr_back_to_back[%0d] got=01 exp=00", k); end
      prev_acr = (packet_type === 8'h01);
      if (prev_acr) acr_cnt++;
    end
    total++;
    if (acr_cnt !== 4) begin bad++; $display("FAIL acr_count got=%0d exp=4", acr_cnt); end
  endtask

  task automatic test_priority();
    pkt_t       e;
    int         n;
    logic [7:0] want [3];
    want = '{8'h02, 8'h01, 8'h84};
    idle(32);
    cycle(1'b0, 1'b1, 1'b1, rnd_word());
    n = 0;
    while (!m_acr && n < 2 * ACR_N) begin idle(1); n++; end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      e = exp_q.pop_front();
      total++;
      if (packet_type !== want[k] || dut_pkt() !== e) begin
        bad++; $display("FAIL priority[%0d] type=%h exp=%h pkt=%h", k, packet_type, want[k], dut_pkt());
      end
      idle(31);
    end
  endtask

  task automatic test_frame_wrap();
    pkt_t       e;
    logic [7:0] fc_before;
    for (int i = 0; i < 192; i++) begin
      cycle(1'b0, 1'b0, 1'b1, rnd_word());
      idle(30);
      fc_before = m_fc;
      cycle(1'b1, 1'b0, 1'b0, '0);
      e = exp_q.pop_front();
      total++;
      if (dut_pkt() !== e) begin bad++; $display("FAIL wrap_pkt[%0d] got=%h exp=%h", i, dut_pkt(), e); end
      total++;
      if (header[20] !== (fc_before == 8'd0)) begin
        bad++; $display("FAIL b_flag[%0d] got=%b exp=%b", i, header[20], fc_before == 8'd0);
      end
      if (fc_before == 8'd191) begin
        total++;
        if (frame_counter !== 8'd0) begin bad++; $display("FAIL fc_wrap got=%0d exp=0", frame_counter); end
      end
    end
  endtask

  task automatic test_acr_coincident();
    pkt_t e;
    int   n;
    idle(32);
    n = 0;
    while (!(m_timer == ACR_N - 1 && m_acr) && n < 3 * ACR_N) begin idle(1); n++; end
    total++;
    if (n >= 3 * ACR_N) begin bad++; $display("FAIL coincide_wait got=timeout exp=aligned"); end
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      e = exp_q.pop_front();
      total++;
      if (packet_type !== 8'h01 || dut_pkt() !== e) begin
        bad++; $display("FAIL coincide_acr[%0d] got=%h exp=%h", k, dut_pkt(), e);
      end
      idle(31);
    end
    cycle(1'b0, 1'b0, 1'b1, rnd_word());
    cycle(1'b0, 1'b0, 1'b1, rnd_word());
    idle(30);
    cycle(1'b1, 1'b0, 1'b1, rnd_word());
    e = exp_q.pop_front();
    total++;
    if (dut_pkt() !== e) begin bad++; $display("FAIL pushpop_pkt got=%h exp=%h", dut_pkt(), e); end
    cycle(1'b0, 1'b0, 1'b1, rnd_word());
    total++;
    if (audio_ready !== 1'b1) begin bad++; $display("FAIL pushpop_cnt3_ready got=%b exp=1", audio_ready); end
    cycle(1'b0, 1'b0, 1'b1, rnd_word());
    total++;
    if (audio_ready !== 1'b0) begin bad++; $display("FAIL pushpop_cnt4_ready got=%b exp=0", audio_ready); end
    idle(30);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      e = exp_q.pop_front();
      total++;
      if (packet_type !== 8'h02 || dut_pkt() !== e) begin
        bad++; $display("FAIL pushpop_drain[%0d] got=%h exp=%h", k, dut_pkt(), e);
      end
      idle(31);
    end
  endtask

  task automatic test_reset_midflight();
    pkt_t e;
    cycle(1'b0, 1'b0, 1'b1, rnd_word());
    cycle(1'b0, 1'b1, 1'b1, rnd_word());
    idle(30);
    cycle(1'b1, 1'b0, 1'b0, '0);
    void'(exp_q.pop_front());
    idle(3);
    reset_n = 1'b0;
    #2;
    total++;
    if (dut_pkt() !== NULL_PKT || frame_counter !== 8'd0) begin
      bad++; $display("FAIL midreset_clear pkt=%h fc=%0d exp=0", dut_pkt(), frame_counter);
    end
    total++;
    if (audio_ready !== 1'b1 || audio_sample_word !== 48'd0) begin
      bad++; $display("FAIL midreset_fifo ready=%b head=%h exp ready=1 head=0", audio_ready, audio_sample_word);
    end
    @(posedge clk_pixel);
    #1;
    reset_n = 1'b1;
    model_reset();
    idle(5);
    cycle(1'b1, 1'b0, 1'b0, '0);
    e = exp_q.pop_front();
    total++;
    if (packet_type !== 8'h84 || dut_pkt() !== e) begin
      bad++; $display("FAIL midreset_aif got=%h exp=%h", dut_pkt(), e);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_aif_first();
    test_fill_drain();
    test_acr_period();
    test_priority();
    test_frame_wrap();
    test_acr_coincident();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/packet_scheduler.md
PACKET_SCHEDULER -- requirements
Module: packet_scheduler

Interface
REQ-001 SHALL have parameter ACR_INTERVAL, default 25200: number of clk_pixel cycles between Audio Clock Regeneration packet requests.
REQ-002 SHALL have parameter AUDIO_FIFO_DEPTH, default 4: number of stereo sample-pair entries; power of two, at least 2.
REQ-003 SHALL have one clock and an asynchronous active-low reset; ports are listed in REQ-004 to REQ-018.
REQ-004 clk_pixel  in  1  pixel clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 packet_slot  in  1  single-cycle pulse marking the start of a data-island packet slot; pulses are at least 32 cycles apart.
REQ-007 video_field_end  in  1  single-cycle pulse, once per video field.
REQ-008 audio_valid  in  1  an audio sample pair is offered.
REQ-009 audio_ready  out  1  the scheduler can accept a sample pair.
REQ-010 audio_sample_word_in  in  2x24  [0]=left, [1]=right.
REQ-011 frame_counter  out  8  IEC 60958 frame index sent to the sample-packet generator.
REQ-012 audio_sample_word  out  2x24  FIFO head, sent to the sample-packet generator.
REQ-013 asp_header/asp_sub  in  24 / 4x56  audio sample packet from the generator.
REQ-014 acr_header/acr_sub  in  24 / 4x56  clock regeneration packet.
REQ-015 aif_header/aif_sub  in  24 / 4x56  audio InfoFrame.
REQ-016 header  out  24  selected packet header.
REQ-017 sub  out  4x56  selected packet subpackets.
REQ-018 packet_type  out  8  selected type: 0x00 null, 0x01 ACR, 0x02 sample, 0x84 InfoFrame.

Function
REQ-019 SHALL store sample pairs in an internal FIFO of AUDIO_FIFO_DEPTH entries.
REQ-020 SHALL drive audio_ready = FIFO not full, combinationally from the occupancy count.
REQ-021 SHALL push when audio_valid && audio_ready.
REQ-022 SHALL leave the count unchanged on a simultaneous push and pop.
REQ-023 SHALL drive audio_sample_word from the FIFO head at all times; the value is undefined-safe (zero) when the FIFO is empty.
REQ-024 ACR timer: SHALL count 0..ACR_INTERVAL-1 and wrap; at terminal count it sets acr_pending.
REQ-025 ACR timer: a set while acr_pending is already 1 has no further effect (requests do not accumulate).
REQ-026 SHALL set aif_pending on video_field_end.
REQ-027 On a packet_slot cycle, SHALL select one packet in priority order:
  - sample (FIFO not empty)
  - ACR (acr_pending)
  - InfoFrame (aif_pending)
  - null
REQ-028 SHALL register the selection on the edge ending the packet_slot cycle, so header/sub/packet_type update 1 cycle after packet_slot.
REQ-029 SHALL hold header/sub/packet_type constant until the next selection.
REQ-030 Null packet: header=0, sub=all 0, packet_type=0x00.
REQ-031 Sample selected: SHALL register asp_header/asp_sub as sampled in the packet_slot cycle.
REQ-032 Sample selected: on the same edge SHALL pop the FIFO and advance frame_counter (191 wraps to 0).
REQ-033 ACR selected: SHALL clear acr_pending on the same edge, unless the timer terminal count occurs in that cycle, in which case acr_pending stays 1.
REQ-034 InfoFrame selected: SHALL clear aif_pending under the same rule with video_field_end.
REQ-035 Without packet_slot, SHALL NOT pop, change frame_counter or clear pending flags.
REQ-036 Selection logic is combinational; asp inputs depend only on frame_counter and audio_sample_word, so no combinational loop exists.

Reset
REQ-037 On reset_n low, SHALL immediately clear:
  - header, sub, packet_type, frame_counter
  - FIFO count and pointers
  - ACR timer, acr_pending
REQ-038 On reset_n low, SHALL set aif_pending=1, so the first slot after reset with an empty FIFO sends the InfoFrame.
REQ-039 audio_ready=1 during and after reset.
REQ-040 Reset asserted mid-packet discards in-flight selection and buffered samples; operation resumes from REQ-037/038 state on the first edge after release.

Verification
REQ-041 Reset release, empty FIFO, packet_slot at cycle 10 -> cycle 11: packet_type=0x84, header=aif_header. Next slot -> 0x00 with all-zero header/sub.
REQ-042 Push 4 pairs back-to-back (DEPTH=4) -> audio_ready=0 after the 4th. Next 4 slots -> packet_type=0x02 each, frame_counter 0,1,2,3 at the respective slots, audio_ready=1 after the first pop.
REQ-043 ACR_INTERVAL=100, no audio, slots every 40 cycles -> one 0x01 packet at the first slot after each terminal count. No back-to-back ACR packets.
REQ-044 FIFO non-empty with acr_pending and aif_pending all set -> three consecutive slots give 0x02 (while samples remain), then 0x01, then 0x84.
REQ-045 Issue 192 sample packets -> frame_counter wraps 191->0. asp_header bit 20 (B flag, from generator) is seen at frame_counter=0 only.
REQ-046 Terminal count coincident with a slot granting ACR -> acr_pending remains 1 and the next slot sends ACR again. Push with pop on a full FIFO is impossible (audio_ready=0); push with pop at count 2 keeps count 2.
